ula_serial_ctrl: RTL and testbench

// - Initiator for the 4-bit ula_74181 slice. Runs one WIDTH-bit ALU operation
//   as NIBBLES sequential passes through an external ula_74181, LSB nibble first.
// - Drives the slice's a/b/s/m/c_in inputs and captures f/c_out/a_eq_b each pass.
// - Ripples the carry from one pass to the next and assembles the wide result and flags.

---
 rtl/ula_pkg.sv | 26 ++
 rtl/ula_74181.sv | 81 ++++++++
 rtl/ula_serial_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_ula_serial_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Purpose : shared types and constants for the serial 74181 initiator and the
//           behavioural 4-bit slice it drives.
// Contents: ula_seq_state_t  - sequencer state encoding (IDLE/RUN/DONE)
//           S_ADD/S_SUB      - arithmetic select codes (m = 0)
//           S_XOR/S_XNOR     - logic select codes (m = 1)
//           chain_breaks()   - arithmetic selects whose carry-out is forced 0
package ula_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ula_seq_state_t;

    localparam logic [3:0] S_ADD  = 4'b1001;
    localparam logic [3:0] S_SUB  = 4'b0110;
    localparam logic [3:0] S_XOR  = 4'b0110;
    localparam logic [3:0] S_XNOR = 4'b1001;

    // Selects 0011/0111/1011/1111 in arithmetic mode produce no carry-out,
    // so a multi-nibble chain stops propagating after nibble 0.
    function automatic logic chain_breaks(input logic [3:0] s);
        return (s[1:0] == 2'b11);
    endfunction

endpackage

// File: rtl/ula_74181.sv
// Purpose : behavioural 4-bit ALU slice in the style of the 74181, used beside
//           ula_serial_ctrl. Purely combinational.
//           Arithmetic (m = 0): add-type selects treat c_in/c_out as carry,
//           subtract-type selects treat them as borrow (c_out = 1 on borrow).
//           Logic (m = 1): c_in ignored, c_out = 0.
// Ports   : a, b    in  4  operand nibbles
//           s       in  4  function select
//           m       in  1  1 = logic, 0 = arithmetic
//           c_in    in  1  carry / borrow in
//           f       out 4  result nibble
//           c_out   out 4  bit 0 = carry / borrow out, bits 3:1 always 0
//           a_eq_b  out 1  a == b
module ula_74181
    import ula_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       c_in,
    output logic [3:0] f,
    output logic [3:0] c_out,
    output logic       a_eq_b
);

    logic [4:0] wide;

    always_comb begin
        f     = 4'h0;
        c_out = 4'h0;
        wide  = 5'h00;
        if (m) begin
            case (s)
                4'b0000: f = ~a;
                4'b0001: f = ~(a | b);
                4'b0010: f = ~a & b;
                4'b0011: f = 4'h0;
                4'b0100: f = ~(a & b);
                4'b0101: f = ~b;
                4'b0110: f = a ^ b;
                4'b0111: f = a & ~b;
                4'b1000: f = ~a | b;
                4'b1001: f = ~(a ^ b);
                4'b1010: f = b;
                4'b1011: f = a & b;
                4'b1100: f = 4'hF;
                4'b1101: f = a | ~b;
                4'b1110: f = a | b;
                default: f = a;
            endcase
        end else begin
            case (s)
                S_ADD: begin
                    wide     = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};
                    f        = wide[3:0];
                    c_out[0] = wide[4];
                end
                S_SUB: begin
                    // Bit 4 of the 5-bit difference is set exactly when a borrow occurs.
                    wide     = {1'b0, a} - {1'b0, b} - {4'b0000, c_in};
                    f        = wide[3:0];
                    c_out[0] = wide[4];
                end
                4'b0011: f = 4'h0 - {3'b000, c_in};
                4'b0111: f = (a & ~b) - {3'b000, c_in};
                4'b1011: f = (a & b) - {3'b000, c_in};
                4'b1111: f = a - {3'b000, c_in};
                default: begin
                    wide     = {1'b0, a} + {4'b0000, c_in};
                    f        = wide[3:0];
                    c_out[0] = wide[4];
                end
            endcase
            if (chain_breaks(s)) begin
                c_out = 4'h0;
            end
        end
        a_eq_b = (a == b);
    end

endmodule

// File: rtl/ula_serial_ctrl.sv
// Purpose : runs one WIDTH-bit ALU operation as NIBBLES passes through an
//           external combinational ula_74181 slice, LSB nibble first, rippling
//           the carry between passes and assembling the wide result and flags.
//           WIDTH must be a multiple of 4 and at least 8.
// Ports   : clk, rst_n             clock, asynchronous active-low reset
//           start                  request, sampled only in IDLE
//           op_a, op_b, op_s,      operation, latched on an accepted start
//           op_m, op_c_in
//           busy                   high in RUN and DONE
//           done                   one-cycle pulse, result and flags valid
//           result                 assembled F, held until overwritten
//           carry_out, zero,       flags of the last completed operation
//           a_eq_b_all
//           alu_a, alu_b, alu_s,   drive to the slice
//           alu_m, alu_c_in
//           alu_f, alu_c_out,      response from the slice
//           alu_a_eq_b
module ula_serial_ctrl
    import ula_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [3:0]       op_s,
    input  logic             op_m,
    input  logic             op_c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             a_eq_b_all,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [3:0]       alu_s,
    output logic             alu_m,
    output logic             alu_c_in,
    input  logic [3:0]       alu_f,
    input  logic [3:0]       alu_c_out,
    input  logic             alu_a_eq_b
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    ula_seq_state_t   state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       s_q, s_d;
    logic             m_q, m_d;
    logic             carry_q, carry_d;
    logic             eq_acc_q, eq_acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             zero_q, zero_d;
    logic             eq_all_q, eq_all_d;

    // Only bit 0 of the slice carry takes part in the chain.
    logic unused_c_out_hi;
    assign unused_c_out_hi = ^alu_c_out[3:1];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: the nibble mux is only live during RUN
    always_comb begin
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        alu_a    = 4'h0;
        alu_b    = 4'h0;
        alu_c_in = 1'b0;
        if (state_q == RUN) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    alu_a = a_q[4*i +: 4];
                    alu_b = b_q[4*i +: 4];
                end
            end
            alu_c_in = carry_q;
        end
    end

    assign alu_s      = s_q;
    assign alu_m      = m_q;
    assign result     = result_q;
    assign carry_out  = carry_out_q;
    assign zero       = zero_q;
    assign a_eq_b_all = eq_all_q;

    // Datapath next-state: the slice is combinational, so each RUN cycle
    // captures the nibble it is driving.
    always_comb begin
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        s_d         = s_q;
        m_d         = m_q;
        carry_d     = carry_q;
        eq_acc_d    = eq_acc_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        zero_d      = zero_q;
        eq_all_d    = eq_all_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = op_a;
                    b_d      = op_b;
                    s_d      = op_s;
                    m_d      = op_m;
                    carry_d  = op_c_in;
                    eq_acc_d = 1'b1;
                    idx_d    = '0;
                end
            end
            RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        result_d[4*i +: 4] = alu_f;
                    end
                end
                carry_d  = alu_c_out[0];
                eq_acc_d = eq_acc_q & alu_a_eq_b;
                if (idx_q == LAST_IDX) begin
                    // Flags are registered with the last nibble so they are
                    // valid together with done.
                    idx_d       = '0;
                    carry_out_d = alu_c_out[0];
                    zero_d      = (result_d == '0);
                    eq_all_d    = eq_acc_d;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= 4'h0;
            m_q         <= 1'b0;
            carry_q     <= 1'b0;
            eq_acc_q    <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            zero_q      <= 1'b0;
            eq_all_q    <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s_q         <= s_d;
            m_q         <= m_d;
            carry_q     <= carry_d;
            eq_acc_q    <= eq_acc_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            zero_q      <= zero_d;
            eq_all_q    <= eq_all_d;
        end
    end

endmodule

// File: tb/tb_ula_serial_ctrl.sv
module tb_ula_serial_ctrl;
    import ula_pkg::*;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] op_a = '0;
    logic [WIDTH-1:0] op_b = '0;
    logic [3:0]       op_s = 4'h0;
    logic             op_m = 1'b0;
    logic             op_c_in = 1'b0;
    logic             busy, done, carry_out, zero, a_eq_b_all;
    logic [WIDTH-1:0] result;
    logic [3:0]       alu_a, alu_b, alu_s, alu_f, alu_c_out;
    logic             alu_m, alu_c_in, alu_a_eq_b;

    ula_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m), .op_c_in(op_c_in),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out),
        .zero(zero), .a_eq_b_all(a_eq_b_all),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m),
        .alu_c_in(alu_c_in), .alu_f(alu_f), .alu_c_out(alu_c_out),
        .alu_a_eq_b(alu_a_eq_b)
    );

    ula_74181 slice (
        .a(alu_a), .b(alu_b), .s(alu_s), .m(alu_m), .c_in(alu_c_in),
        .f(alu_f), .c_out(alu_c_out), .a_eq_b(alu_a_eq_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [3:0]       s;
        logic             m;
        logic             cin;
        logic [WIDTH-1:0] res;
        logic             cout;
        logic             zero;
        logic             eq;
    } vec_t;

    vec_t vecs[8];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called just after a negedge; start is sampled at the following posedge.
    task automatic drive_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [3:0] s, input logic m, input logic cin);
        op_a    = a;
        op_b    = b;
        op_s    = s;
        op_m    = m;
        op_c_in = cin;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Runs one operation and returns just after the negedge of the IDLE cycle
    // that follows done, so a following call starts back-to-back.
    task automatic run_op(input vec_t v);
        int lat;
        bit seen;
        drive_op(v.a, v.b, v.s, v.m, v.cin);
        @(negedge clk);
        lat  = 1;
        seen = done;
        check({v.name, " first alu_a"}, 32'(alu_a), 32'(v.a[3:0]));
        check({v.name, " first alu_b"}, 32'(alu_b), 32'(v.b[3:0]));
        check({v.name, " first alu_c_in"}, 32'(alu_c_in), 32'(v.cin));
        check({v.name, " alu_s/alu_m"}, {27'd0, alu_m, alu_s}, {27'd0, v.m, v.s});
        check({v.name, " busy in run"}, 32'(busy), 32'd1);
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            seen = done;
        end
        // Start edge k, RUN in cycles k+1..k+NIB, done in cycle k+NIB+1.
        check({v.name, " done latency"}, 32'(lat), 32'(NIB + 1));
        check({v.name, " result"}, 32'(result), 32'(v.res));
        check({v.name, " carry_out"}, 32'(carry_out), 32'(v.cout));
        check({v.name, " zero"}, 32'(zero), 32'(v.zero));
        check({v.name, " a_eq_b_all"}, 32'(a_eq_b_all), 32'(v.eq));
        @(negedge clk);
        check({v.name, " done one cycle"}, {31'd0, done}, 32'd0);
        check({v.name, " busy after"}, {31'd0, busy}, 32'd0);
        check({v.name, " result held"}, 32'(result), 32'(v.res));
    endtask

    initial begin
        int ndone;
        logic [WIDTH-1:0] seen_res;

        //              name        a        b        s        m     cin   result   cout  zero  eq
        vecs[0] = '{"add",       16'h1234, 16'h0FFF, S_ADD,   1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{"ripple",    16'hFFFF, 16'h0001, S_ADD,   1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{"sub borrow",16'h0005, 16'h0007, S_SUB,   1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{"sub plain", 16'h1000, 16'h0001, S_SUB,   1'b0, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{"xor",       16'hF0F0, 16'hFF00, S_XOR,   1'b1, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{"xnor eq",   16'hABCD, 16'hABCD, S_XNOR,  1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{"broken",    16'h0000, 16'h1234, 4'b1111, 1'b0, 1'b1, 16'h000F, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{"logic zero",16'h5A5A, 16'h1234, 4'b0011, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};

        // Reset state
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset flags", {29'd0, carry_out, zero, a_eq_b_all}, 32'd0);
        check("reset alu_a/alu_b", {24'd0, alu_a, alu_b}, 32'd0);
        check("reset alu_s/m/c_in", {26'd0, alu_s, alu_m, alu_c_in}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table: consecutive entries also exercise start in the cycle after done.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i]);
        end

        // start pulsed during RUN is ignored
        drive_op(16'h0001, 16'h0001, S_ADD, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        op_a  = 16'hFFFF;
        op_b  = 16'hFFFF;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ndone    = 0;
        seen_res = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                seen_res = result;
            end
        end
        check("start in run done count", 32'(ndone), 32'd1);
        check("start in run result", 32'(seen_res), 32'h0002);
        check("start in run idle", {31'd0, busy}, 32'd0);

        // Reset asserted in the second RUN cycle
        drive_op(16'hFFFF, 16'hFFFF, S_ADD, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid reset busy", {31'd0, busy}, 32'd0);
        check("mid reset done", {31'd0, done}, 32'd0);
        check("mid reset result", 32'(result), 32'd0);
        check("mid reset alu drive", {23'd0, alu_a, alu_b, alu_c_in}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("mid reset no done", 32'(ndone), 32'd0);
        check("mid reset result stays", 32'(result), 32'd0);

        // Explicit back-to-back pair after reset
        run_op(vecs[0]);
        run_op(vecs[2]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
